// File: rtl/iir_pkg.sv
// Shared float32 types, constants and helpers for the iir_filter datapath.
package iir_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_MAX_POS = 32'h7F7F_FFFF;
  localparam logic [31:0] FP_MAX_NEG = 32'hFF7F_FFFF;
  localparam int          EXP_BIAS   = 127;

  // Denormals count as zero throughout the datapath.
  function automatic logic fp_is_zero(input fp32_t v);
    return v.exp == 8'd0;
  endfunction

  function automatic fp32_t fp_scale_pow2(input fp32_t v, input int unsigned shift);
    fp32_t r;
    r = v;
    if (fp_is_zero(v) || ({24'd0, v.exp} <= shift)) begin
      r = FP_ZERO;
    end else begin
      r.exp = v.exp - 8'(shift);
    end
    return r;
  endfunction

endpackage

// File: rtl/iir_filter_fp_addsub.sv
// Combinational float32 add/subtract with flush-to-zero and saturation.
// Define IIR_ROUND_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_addsub
  import iir_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_result
);

  localparam logic signed [9:0] EXP_OVF = 10'(2 * EXP_BIAS + 1);

  function automatic fp32_t sanitize(input fp32_t v);
    fp32_t r;
    r = v;
    if (v.exp == 8'd0)       r = {v.sign, 31'd0};
    else if (v.exp == 8'hFF) r = {v.sign, FP_MAX_POS[30:0]};
    return r;
  endfunction

  fp32_t              w_a, w_b, w_big, w_small;
  logic               w_swap;
  logic [7:0]         w_dexp;
  logic [26:0]        w_big_m, w_small_m, w_small_al, w_mask, w_norm;
  logic               w_sticky;
  logic [27:0]        w_sum;
  logic [4:0]         w_lzc;
  logic signed [9:0]  w_exp, w_exp_r;
  logic [22:0]        w_man;
  logic               w_unused;
`ifdef IIR_ROUND_EN
  logic               w_rnd_up;
  logic [24:0]        w_man_r;
`endif

  always_comb begin
    o_result = FP_ZERO;
    w_a      = sanitize(i_a);
    w_b      = sanitize(i_b ^ {i_sub, 31'd0});
    w_swap   = {w_b.exp, w_b.man} > {w_a.exp, w_a.man};
    w_big    = w_swap ? w_b : w_a;
    w_small  = w_swap ? w_a : w_b;
    w_dexp   = w_big.exp - w_small.exp;

    // Mantissas carry three extra bits below the LSB: guard, round, sticky.
    w_big_m    = {|w_big.exp, w_big.man, 3'b000};
    w_small_m  = {|w_small.exp, w_small.man, 3'b000};
    w_mask     = (27'd1 << w_dexp) - 27'd1;
    w_sticky   = |(w_small_m & w_mask);
    w_small_al = (w_small_m >> w_dexp) | {26'd0, w_sticky};

    if (w_big.sign ^ w_small.sign) w_sum = {1'b0, w_big_m} - {1'b0, w_small_al};
    else                           w_sum = {1'b0, w_big_m} + {1'b0, w_small_al};

    w_lzc = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (w_sum[i]) w_lzc = 5'(26 - i);
    end

    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
      w_exp  = $signed({2'b00, w_big.exp}) + 10'sd1;
    end else begin
      w_norm = w_sum[26:0] << w_lzc;
      w_exp  = $signed({2'b00, w_big.exp}) - $signed({5'd0, w_lzc});
    end

`ifdef IIR_ROUND_EN
    w_rnd_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_man_r  = {1'b0, w_norm[26:3]} + {24'd0, w_rnd_up};
    if (w_man_r[24]) begin
      w_man   = 23'd0;
      w_exp_r = w_exp + 10'sd1;
    end else begin
      w_man   = w_man_r[22:0];
      w_exp_r = w_exp;
    end
`else
    w_man   = w_norm[25:3];
    w_exp_r = w_exp;
`endif

    if (w_sum == 28'd0 || w_exp_r <= 10'sd0) o_result = FP_ZERO;
    else if (w_exp_r >= EXP_OVF)             o_result = w_big.sign ? FP_MAX_NEG : FP_MAX_POS;
    else                                     o_result = {w_big.sign, w_exp_r[7:0], w_man};
  end

`ifdef IIR_ROUND_EN
  assign w_unused = ^{w_norm[26], w_man_r[23]};
`else
  assign w_unused = ^{w_norm[26], w_norm[2:0]};
`endif

endmodule

// File: rtl/iir_filter.sv
// Single-pole float32 low-pass: y <= y + (x - y) * 2^-SHIFT, one sample per clock.
// Rounding mode follows IIR_ROUND_EN inside fp_addsub.
module iir_filter
  import iir_pkg::*;
#(
  parameter int unsigned SHIFT = 3
)
(
  input  logic        clk,
  input  logic        reset_l,
  input  logic [31:0] i_signal,
  output logic [31:0] o_signal
);

  logic [31:0] r_y;
  logic [31:0] w_diff;
  logic [31:0] w_scaled;
  logic [31:0] w_sum;

  fp_addsub u_diff (
    .i_a      (i_signal),
    .i_b      (r_y),
    .i_sub    (1'b1),
    .o_result (w_diff)
  );

  assign w_scaled = fp_scale_pow2(w_diff, SHIFT);

  fp_addsub u_acc (
    .i_a      (r_y),
    .i_b      (w_scaled),
    .i_sub    (1'b0),
    .o_result (w_sum)
  );

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) r_y <= FP_ZERO;
    else          r_y <= w_sum;
  end

  assign o_signal = r_y;

endmodule

// File: tb/tb_iir_filter.sv
// Directed self-checking bench for iir_filter: exact values via a scoreboard queue,
// convergence/decay properties via a real-valued reference.
module tb_iir_filter;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [31:0] i_signal;
  logic [31:0] o_signal;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prev_bits;
  real         prev_r, cur_r, ulp_r;
  bit          ok;

  always #5 clk = ~clk;

  iir_filter #(.SHIFT(3)) dut (
    .clk      (clk),
    .reset_l  (reset_l),
    .i_signal (i_signal),
    .o_signal (o_signal)
  );

  function automatic real f2r(input logic [31:0] v);
    real m;
    int  e;
    if (v[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(v[22:0]) / 8388608.0;
    e = int'(v[30:23]) - 127;
    if (e > 0) for (int k = 0; k < e; k++) m = m * 2.0;
    else       for (int k = 0; k < -e; k++) m = m / 2.0;
    return v[31] ? -m : m;
  endfunction

  function automatic real rabs(input real a);
    return (a < 0.0) ? -a : a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  task automatic check_true(input string tag, input bit cond, input logic [31:0] obs, input string req);
    n_assert++;
    assert (cond === 1'b1)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h required %s", tag, obs, req);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL %s: observed %08h required a queued expectation (queue empty)", tag, o_signal);
    end else begin
      e = exp_q.pop_front();
      $display("txn %-12s o=%08h exp=%08h", tag, o_signal, e);
      check(tag, o_signal, e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required $finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_l  = 1'b1;
    i_signal = 32'h43FA0000;
    #2 reset_l = 1'b0;

    // Reset held low: y stays 0 across edges despite a nonzero input.
    repeat (3) begin push(32'h0); tick(); pop_check("reset_hold"); end

    i_signal = 32'h0;
    reset_l  = 1'b1;
    repeat (5) begin push(32'h0); tick(); pop_check("zero_in"); end

    // Step to 500.0
    i_signal = 32'h43FA0000;
    push(32'h427A0000); tick(); pop_check("step_e1");
    push(32'h42EA6000); tick(); pop_check("step_e2");
    prev_r = f2r(o_signal);
    cur_r  = prev_r;
    repeat (198) begin
      tick();
      cur_r = f2r(o_signal);
      check_true("step_mono", (cur_r <= 500.0) && (cur_r >= prev_r), o_signal, "prev <= y <= 500.0");
      prev_r = cur_r;
    end
    $display("txn step_conv    y=%f", cur_r);
    check_true("step_conv", rabs(500.0 - cur_r) < 0.001, o_signal, "|y-500| < 0.001");

    // Decay: each edge y*7/8 within 1 ULP until y*2^-3 flushes (exp(y) <= 3), then y holds.
    i_signal = 32'h0;
    repeat (800) begin
      prev_bits = o_signal;
      prev_r    = f2r(prev_bits);
      tick();
      cur_r = f2r(o_signal);
      ulp_r = f2r({1'b0, o_signal[30:23], 23'd0}) / 8388608.0;
      if (prev_bits[30:23] > 8'd3)
        ok = !o_signal[31] && (cur_r < prev_r) && (rabs(cur_r - prev_r * 0.875) <= ulp_r);
      else
        ok = (o_signal === prev_bits);
      check_true("decay_step", ok, o_signal, "y*7/8 within 1 ULP, non-negative, monotonic");
    end
    $display("txn decay_end    o=%08h", o_signal);
    check_true("decay_end", !o_signal[31] && (o_signal < 32'h02000000), o_signal, "+0 or smallest binades, positive");

    // Asynchronous reset mid-cycle clears y before the next edge.
    #2 reset_l = 1'b0;
    #1 push(32'h0); pop_check("async_rst_a");
    #1 reset_l = 1'b1;

    // Negative step
    i_signal = 32'hC3FA0000;
    push(32'hC27A0000); tick(); pop_check("neg_e1");
    push(32'hC2EA6000); tick(); pop_check("neg_e2");
    prev_r = f2r(o_signal);
    repeat (40) begin
      tick();
      cur_r = f2r(o_signal);
      check_true("neg_mono", o_signal[31] && (cur_r <= prev_r) && (cur_r >= -500.0), o_signal, "negative, -500 <= y <= prev");
      prev_r = cur_r;
    end
    #2 reset_l = 1'b0;
    #1 push(32'h0); pop_check("async_rst_b");
    push(32'h0); tick(); pop_check("rst_low_edge");
    #2 reset_l = 1'b1;

    // +Inf input behaves as max finite magnitude.
    i_signal = 32'h7F800000;
    push(32'h7DFFFFFF); tick(); pop_check("pinf_e1");
    repeat (300) begin
      tick();
      check_true("pinf_finite", (o_signal[30:23] != 8'hFF) && !o_signal[31] && (o_signal != 32'h0), o_signal, "finite positive, not Inf/NaN");
    end
    #2 reset_l = 1'b0;
    #2 reset_l = 1'b1;

    i_signal = 32'hFF800000;
    push(32'hFDFFFFFF); tick(); pop_check("ninf_e1");
    #2 reset_l = 1'b0;
    #2 reset_l = 1'b1;

    // Denormal input is treated as zero.
    i_signal = 32'h00000001;
    repeat (5) begin push(32'h0); tick(); pop_check("denorm_in"); end

    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_drain: observed %0d pending required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
